// File: rtl/intr_pkg.sv
// Shared constants for the interrupt controller: register map, FSM encoding, CAUSE layout.
// Latency: n/a (package only); backpressure: n/a.
package intr_pkg;

  localparam logic [1:0] REG_MASK  = 2'd0;
  localparam logic [1:0] REG_PEND  = 2'd1;
  localparam logic [1:0] REG_CAUSE = 2'd2;
  localparam logic [1:0] REG_EOI   = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam int CAUSE_INSVC_BIT = 31;

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-index-first priority encoder over an N_SRC-bit request vector.
// Latency: combinational; backpressure: none.
module intr_prio_enc #(
  parameter int N_SRC   = 8,
  parameter int CAUSE_W = 3
) (
  input  logic [N_SRC-1:0]   req,
  output logic               idx_vld,
  output logic [CAUSE_W-1:0] idx
);

  always_comb begin
    idx_vld = |req;
    idx     = '0;
    // Descending scan so the lowest set bit is the last assignment to land.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = CAUSE_W'(i);
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Edge-triggered, maskable interrupt controller with intr/inta handshake and a 4-entry register file.
// Latency: 1 cycle from pending visible to intr high; no backpressure, intr held until inta.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int N_SRC   = 8,
  parameter int CAUSE_W = 3
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic [N_SRC-1:0]   irq_src,
  input  logic               inta,
  output logic               intr,
  output logic [CAUSE_W-1:0] cause_id,
  output logic               in_service,
  input  logic               reg_we,
  input  logic [1:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata
);

  state_t             state_q;
  state_t             state_d;
  logic [N_SRC-1:0]   irq_prev;
  logic [N_SRC-1:0]   pending;
  logic [N_SRC-1:0]   pending_d;
  logic [N_SRC-1:0]   mask;
  logic [N_SRC-1:0]   pend_clr;
  logic               arb_vld;
  logic [CAUSE_W-1:0] arb_idx;
  logic               accept;
  logic               ack;
  logic               wr_mask;
  logic               wr_pend;
  logic               wr_eoi;
  logic               unused_wdata;

  assign wr_mask      = reg_we && (reg_addr == REG_MASK);
  assign wr_pend      = reg_we && (reg_addr == REG_PEND);
  assign wr_eoi       = reg_we && (reg_addr == REG_EOI);
  assign unused_wdata = ^reg_wdata;

  intr_prio_enc #(
    .N_SRC   (N_SRC),
    .CAUSE_W (CAUSE_W)
  ) u_prio_enc (
    .req     (pending & mask),
    .idx_vld (arb_vld),
    .idx     (arb_idx)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    ack     = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          state_d = REQ;
          accept  = 1'b1;
        end
      end
      REQ: begin
        if (inta) begin
          state_d = SERVICE;
          ack     = 1'b1;
        end
      end
      SERVICE: begin
        if (wr_eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A new rising edge re-sets the bit even if W1C or acknowledge clears it this cycle.
  always_comb begin
    pend_clr = wr_pend ? reg_wdata[N_SRC-1:0] : '0;
    if (ack) pend_clr = pend_clr | (N_SRC'(1) << cause_id);
    pending_d = (pending & ~pend_clr) | (irq_src & ~irq_prev);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= IDLE;
      irq_prev   <= '0;
      pending    <= '0;
      mask       <= '0;
      cause_id   <= '0;
      intr       <= 1'b0;
      in_service <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_prev   <= irq_src;
      pending    <= pending_d;
      if (wr_mask) mask <= reg_wdata[N_SRC-1:0];
      if (accept) cause_id <= arb_idx;
      intr       <= (state_d == REQ);
      in_service <= (state_d == SERVICE);
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      REG_MASK:  reg_rdata[N_SRC-1:0] = mask;
      REG_PEND:  reg_rdata[N_SRC-1:0] = pending;
      REG_CAUSE: begin
        reg_rdata[CAUSE_INSVC_BIT] = in_service;
        reg_rdata[CAUSE_W-1:0]     = cause_id;
      end
      default:   reg_rdata = '0;
    endcase
  end

endmodule
